rj_serial_loader: RTL and testbench
===================================

# rj_serial_loader

Serial-to-parallel front end for the Rj register memory: captures MSB-first 16-bit words arriving on a one-bit serial input and frames them with the `Frame` pulse. It writes a fixed-length sequence of words into consecutive memory addresses 0..WORDS-1. The block sits directly upstream of the 16x16 Rj store and drives that store's write port (enable, address, data) during the Rj load phase.

## Interface
- `WIDTH`, 16: bits per serial word.
- `WORDS`, 16: words per load sequence; must be a power of two and at most 2^ADDR_W.
- `ADDR_W`, 4: write-address width.

- `Sclk` input 1: system clock; all state updates on the rising edge.
- `Reset_n` input 1: asynchronous active-low reset; one clock, reset asynchronous active-low.
- `load_start` input 1: single-cycle request to begin a load sequence; honoured only in IDLE or DONE.
- `Frame` input 1: word-start strobe, high for the one cycle in which `Din` carries the MSB.
- `Din` input 1: serial data, MSB first, one bit per `Sclk` cycle.
- `write_enable` output 1: one-cycle write strobe to the Rj store.
- `Write_Address` output ADDR_W: target address, valid while `write_enable` is high.
- `data_out` output WIDTH: assembled word, valid while `write_enable` is high.
- `busy` output 1: high in ARMED and SHIFT.
- `load_done` output 1: high in DONE.
- `sync_err` output 1: sticky flag set when `Frame` arrives mid-word; cleared by reset or an accepted `load_start`.

## Operation
- States:
  - IDLE: reset state.
  - ARMED: waiting for `Frame`.
  - SHIFT: receiving the bits of a word.
  - DONE: sequence complete.
- IDLE/DONE + `load_start`:
  - go to ARMED.
  - word counter = 0; `sync_err` = 0.
  - if `Frame` is high in the same cycle, treat as ARMED + `Frame` (the word starts now).
- ARMED + `Frame`:
  - shift register gets `Din` in its LSB.
  - bit counter = 1.
  - go to SHIFT.
- ARMED without `Frame`: hold; `Din` is ignored.
- SHIFT, `Frame` low: shift left, inserting `Din` as LSB; bit counter += 1.
- On the WIDTH-th bit (bit counter == WIDTH-1 before the update):
  - `data_out` = the completed word.
  - `Write_Address` = word counter.
  - `write_enable` = 1 for the next cycle only.
  - word counter += 1.
  - If this was word WORDS-1, go to DONE; otherwise go to ARMED.
- SHIFT, `Frame` high with bit counter != 0 (resync):
  - discard the partial word; no write.
  - set `sync_err`.
  - restart the word with `Din` as MSB; bit counter = 1.
- `Frame` and `load_start` are ignored in IDLE and DONE, apart from `load_start` restarting a sequence as above. `load_start` is ignored while `busy`.
- Reset values:
  - state IDLE.
  - `write_enable` 0, `Write_Address` 0, `data_out` 0.
  - `busy` 0, `load_done` 0, `sync_err` 0.
  - bit counter and word counter 0.
- Reset mid-word or mid-sequence: the partial word is lost, no write is issued, and the counters clear.
- `Write_Address` and `data_out` hold their last values between strobes.

## Timing
- `Frame` and MSB are sampled at rising edge k. Bits are sampled at edges k..k+WIDTH-1.
- `write_enable` is high from edge k+WIDTH to edge k+WIDTH+1, giving exactly one full `Sclk` period. The consumer may sample on the falling edge inside that period.
- Back-to-back words are allowed: the next `Frame` may arrive at edge k+WIDTH. The shift register and the output register are separate, so there are no gap cycles.
- `load_done` rises at the same edge that `write_enable` rises for word WORDS-1. It stays high until the cycle after an accepted `load_start`.
- `busy` falls at the same edge that `load_done` rises.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then hold `Frame`/`Din` idle for 20 cycles:
  - all outputs stay 0.
  - no `write_enable`.
- `load_start`, then 16 back-to-back words with values 0x0001, 0x0002 … 0x0010 (each `Frame` 16 cycles after the previous one):
  - 16 single-cycle strobes.
  - addresses 0..15, data matching the words.
  - `load_done` rises with the 16th strobe.
  - `sync_err` stays 0.
- Word 0xA5C3 with 5 idle cycles before its `Frame`, then word 0xFFFF:
  - strobe 16 cycles after each `Frame`.
  - addresses 0 then 1.
  - no spurious strobe during the gap.
- `Frame` re-asserted at bit 7 of a word, followed by a full word 0x1234:
  - `sync_err` = 1.
  - a single strobe with data 0x1234, address unchanged from before the aborted word.
- `Reset_n` pulsed low at bit 9 of word 3:
  - outputs clear immediately.
  - no strobe for that word.
  - after reset, `load_start` plus one word gives a strobe at address 0.
- `load_start` pulsed while `busy`, and `Frame` pulsed in DONE:
  - both ignored.
  - a `load_start` accepted in DONE clears `load_done` and restarts at address 0.

Source files
------------

// File: rtl/rj_serial_loader.sv
// Serial-to-parallel loader for the Rj register store: assembles MSB-first
// framed words and writes a fixed-length sequence to addresses 0..WORDS-1.
module rj_serial_loader #(
  parameter int WIDTH  = 16,
  parameter int WORDS  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              Sclk,
  input  logic              Reset_n,
  input  logic              load_start,
  input  logic              Frame,
  input  logic              Din,
  output logic              write_enable,
  output logic [ADDR_W-1:0] Write_Address,
  output logic [WIDTH-1:0]  data_out,
  output logic              busy,
  output logic              load_done,
  output logic              sync_err
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT, DONE} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  shreg, shreg_next;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_next;
  logic [ADDR_W-1:0] word_cnt, word_cnt_next;
  logic              err, err_next;
  logic              wr_pend, wr_pend_next;

  // NOTE: every variable is defaulted first so no path through the case
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next    = state;
    shreg_next    = shreg;
    bit_cnt_next  = bit_cnt;
    word_cnt_next = word_cnt;
    err_next      = err;
    wr_pend_next  = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (load_start) begin
          word_cnt_next = '0;
          err_next      = 1'b0;
          if (Frame) begin
            shreg_next   = {shreg[WIDTH-2:0], Din};
            bit_cnt_next = CNT_W'(1);
            state_next   = SHIFT;
          end else begin
            state_next   = ARMED;
          end
        end
      end
      ARMED: begin
        if (Frame) begin
          shreg_next   = {shreg[WIDTH-2:0], Din};
          bit_cnt_next = CNT_W'(1);
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        shreg_next = {shreg[WIDTH-2:0], Din};
        if (Frame) begin
          // Mid-word frame: drop the partial word and restart from this MSB.
          err_next     = 1'b1;
          bit_cnt_next = CNT_W'(1);
        end else if (bit_cnt == LAST_BIT) begin
          wr_pend_next  = 1'b1;
          bit_cnt_next  = '0;
          word_cnt_next = word_cnt + 1'b1;
          state_next    = (word_cnt == LAST_WORD) ? DONE : ARMED;
        end else begin
          bit_cnt_next  = bit_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      err      <= 1'b0;
      wr_pend  <= 1'b0;
    end else begin
      state    <= state_next;
      shreg    <= shreg_next;
      bit_cnt  <= bit_cnt_next;
      word_cnt <= word_cnt_next;
      err      <= err_next;
      wr_pend  <= wr_pend_next;
    end
  end

  // Output stage: the completed word stays in shreg for one cycle, so it is
  // copied here while a back-to-back word begins shifting in behind it.
  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      write_enable  <= 1'b0;
      Write_Address <= '0;
      data_out      <= '0;
      busy          <= 1'b0;
      load_done     <= 1'b0;
      sync_err      <= 1'b0;
    end else begin
      write_enable <= wr_pend;
      if (wr_pend) begin
        data_out      <= shreg;
        Write_Address <= word_cnt - 1'b1;
      end
      busy      <= (state == ARMED) || (state == SHIFT);
      load_done <= (state == DONE);
      sync_err  <= err;
    end
  end

endmodule

// File: tb/tb_rj_serial_loader.sv
// Self-checking bench for rj_serial_loader: directed scenarios plus randomized
// sequences, checked against a per-word strobe scoreboard keyed by clock edge.
module tb_rj_serial_loader;

  localparam int WIDTH  = 16;
  localparam int WORDS  = 16;
  localparam int ADDR_W = 4;

  logic              Sclk = 1'b0;
  logic              Reset_n;
  logic              load_start;
  logic              Frame;
  logic              Din;
  logic              write_enable;
  logic [ADDR_W-1:0] Write_Address;
  logic [WIDTH-1:0]  data_out;
  logic              busy;
  logic              load_done;
  logic              sync_err;

  rj_serial_loader #(.WIDTH(WIDTH), .WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
    .Sclk          (Sclk),
    .Reset_n       (Reset_n),
    .load_start    (load_start),
    .Frame         (Frame),
    .Din           (Din),
    .write_enable  (write_enable),
    .Write_Address (Write_Address),
    .data_out      (data_out),
    .busy          (busy),
    .load_done     (load_done),
    .sync_err      (sync_err)
  );

  always #5 Sclk = ~Sclk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
    logic              last;
  } ev_t;

  int               checks   = 0;
  int               failures = 0;
  int               cyc      = 0;
  int               wc       = 0;
  logic             exp_err  = 1'b0;
  logic [WIDTH-1:0] last_data = '0;
  ev_t              exp_ev [int];
  ev_t              mon_ev;

  always @(posedge Sclk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Each edge either carries a scheduled strobe or must show none.
  always @(negedge Sclk) begin
    if (exp_ev.exists(cyc)) begin
      mon_ev = exp_ev[cyc];
      check("strobe_we",   32'(write_enable),  1);
      check("strobe_addr", 32'(Write_Address), 32'(mon_ev.addr));
      check("strobe_data", 32'(data_out),      32'(mon_ev.data));
      check("strobe_done", 32'(load_done),     32'(mon_ev.last));
      check("strobe_busy", 32'(busy),          32'(!mon_ev.last));
      exp_ev.delete(cyc);
    end else begin
      check("no_strobe", 32'(write_enable), 0);
    end
  end

  task automatic tick(input logic f, input logic d, input logic s);
    @(negedge Sclk);
    Frame      = f;
    Din        = d;
    load_start = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'($urandom), 1'b0);
  endtask

  task automatic start_seq();
    wc      = 0;
    exp_err = 1'b0;
    tick(1'b0, 1'($urandom), 1'b1);
  endtask

  // Frame sampled at edge k => strobe visible after edge k+WIDTH.
  task automatic send_word(input logic [WIDTH-1:0] w, input logic with_start,
                           input logic mid_start);
    ev_t ev;
    ev.addr = ADDR_W'(wc);
    ev.data = w;
    ev.last = (wc == WORDS - 1);
    tick(1'b1, w[WIDTH-1], with_start);
    exp_ev[cyc + 1 + WIDTH] = ev;
    for (int i = WIDTH - 2; i >= 0; i--) tick(1'b0, w[i], mid_start && (i == WIDTH / 2));
    wc++;
    last_data = w;
  endtask

  task automatic send_partial(input int n);
    tick(1'b1, 1'($urandom), 1'b0);
    for (int i = 1; i < n; i++) tick(1'b0, 1'($urandom), 1'b0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_we"},   32'(write_enable),  0);
    check({tag, "_addr"}, 32'(Write_Address), 0);
    check({tag, "_data"}, 32'(data_out),      0);
    check({tag, "_busy"}, 32'(busy),          0);
    check({tag, "_done"}, 32'(load_done),     0);
    check({tag, "_err"},  32'(sync_err),      0);
  endtask

  initial begin
    Reset_n    = 1'b0;
    Frame      = 1'b0;
    Din        = 1'b0;
    load_start = 1'b0;
    repeat (3) @(negedge Sclk);
    check_quiet("reset");
    Reset_n = 1'b1;
    idle(20);
    check_quiet("idle");

    // Sixteen back-to-back words 1..16, one ignored load_start mid-word.
    start_seq();
    for (int i = 0; i < WORDS; i++) send_word(WIDTH'(i + 1), 1'b0, i == 5);
    idle(3);
    check("seq1_done", 32'(load_done), 1);
    check("seq1_busy", 32'(busy),      0);
    check("seq1_err",  32'(sync_err),  0);

    // Restart from DONE, 5-cycle gap, then two words back to back.
    start_seq();
    tick(1'b0, 1'b0, 1'b0);
    check("done_hold_after_start", 32'(load_done), 1);
    idle(4);
    check("done_cleared", 32'(load_done), 0);
    check("busy_armed",   32'(busy),      1);
    send_word(16'hA5C3, 1'b0, 1'b0);
    send_word(16'hFFFF, 1'b0, 1'b0);
    idle(3);
    check("gap_err", 32'(sync_err), 0);

    // Resync: frame re-asserted after 7 bits, then a full word.
    send_partial(7);
    exp_err = 1'b1;
    send_word(16'h1234, 1'b0, 1'b0);
    idle(3);
    check("resync_err", 32'(sync_err), 1);

    // Reset at bit 9 of word 3 loses the word and clears the counters.
    send_partial(9);
    @(posedge Sclk);
    #2 Reset_n = 1'b0;
    exp_ev.delete();
    wc      = 0;
    exp_err = 1'b0;
    #1 check_quiet("async_reset");
    idle(3);
    Reset_n = 1'b1;
    idle(2);
    check_quiet("post_reset");
    start_seq();
    send_word(WIDTH'($urandom), 1'b0, 1'b0);
    idle(3);

    // Randomized completion of the sequence with gaps, resyncs and ignored starts.
    while (wc < WORDS) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++)
        tick(1'b0, 1'($urandom), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) begin
        send_partial($urandom_range(1, WIDTH - 1));
        exp_err = 1'b1;
      end
      send_word(WIDTH'($urandom), 1'b0, $urandom_range(0, 2) == 0);
    end
    idle(3);
    check("rand_done", 32'(load_done), 1);
    check("rand_busy", 32'(busy),      0);
    check("rand_err",  32'(sync_err),  32'(exp_err));

    // Frames in DONE are ignored and outputs hold the last strobe.
    for (int i = 0; i < 20; i++) tick(1'($urandom), 1'($urandom), 1'b0);
    idle(2);
    check("done_hold",      32'(load_done),     1);
    check("done_hold_addr", 32'(Write_Address), WORDS - 1);
    check("done_hold_data", 32'(data_out),      32'(last_data));

    // Accepted load_start with Frame in the same cycle restarts at address 0.
    wc      = 0;
    exp_err = 1'b0;
    send_word(WIDTH'($urandom), 1'b1, 1'b0);
    idle(20);
    check("restart_done",    32'(load_done),    0);
    check("restart_busy",    32'(busy),         1);
    check("restart_err",     32'(sync_err),     0);
    check("pending_strobes", 32'(exp_ev.num()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
